// File: rtl/iter_power_datapath_pkg.sv
// Shared constants for the iterative power datapath: default sizes, fixed-point one,
// and the sel_t command encodings used by the load/select controller handshake.
package iter_power_datapath_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_FRAC  = 8;
  localparam int unsigned DEF_CNT_W = 4;

  // 1.0 in the default fixed-point format.
  localparam logic [DEF_WIDTH-1:0] ONE_FX = DEF_WIDTH'(1) << DEF_FRAC;

  // sel_t encodings, qualified by load_t.
  localparam logic CMD_INIT = 1'b0;
  localparam logic CMD_ITER = 1'b1;

endpackage

// File: rtl/iter_power_datapath_if.sv
// Controller <-> datapath handshake: command strobe/select and operands in,
// term register, done and overflow back.
interface iter_power_datapath_if
  import iter_power_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CNT_W = DEF_CNT_W
) ();

  logic             load_t;
  logic             sel_t;
  logic [WIDTH-1:0] x_in;
  logic [CNT_W-1:0] exp_in;
  logic [WIDTH-1:0] result;
  logic             datapath_done;
  logic             overflow;

  modport master (
    output load_t, sel_t, x_in, exp_in,
    input  result, datapath_done, overflow
  );

  modport slave (
    input  load_t, sel_t, x_in, exp_in,
    output result, datapath_done, overflow
  );

endinterface

// File: rtl/iter_power_datapath_fx_mul_sat.sv
// Unsigned fixed-point multiply: full-width product, drop FRAC fraction bits,
// saturate to all-ones when the integer part no longer fits in WIDTH bits.
module fx_mul_sat
  import iter_power_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] y_o,
  output logic             ovf_o
);

  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] shifted;

  // Product, rescale and saturate.
  always_comb begin
    prod    = {{WIDTH{1'b0}}, a_i} * {{WIDTH{1'b0}}, b_i};
    shifted = prod >> FRAC;
    ovf_o   = |shifted[2*WIDTH-1:WIDTH];
    y_o     = ovf_o ? {WIDTH{1'b1}} : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/iter_power_datapath.sv
// Iterative x^N datapath: an init command loads the base and exponent, each accepted
// iterate command multiplies the term register by the base once, and done is raised
// when the iteration count reaches the exponent.
module iter_power_datapath
  import iter_power_datapath_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned FRAC  = DEF_FRAC,
  parameter int unsigned CNT_W = DEF_CNT_W
) (
  input logic clk,
  input logic rst,
  iter_power_datapath_if.slave bus
);

  localparam logic [WIDTH-1:0] OneFx = WIDTH'(1) << FRAC;

  logic [WIDTH-1:0] t_d, t_q;
  logic [WIDTH-1:0] x_d, x_q;
  logic [CNT_W-1:0] exp_d, exp_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             valid_d, valid_q;
  logic             ovf_d, ovf_q;

  logic             done;
  logic             init_cmd;
  logic             iter_cmd;
  logic [WIDTH-1:0] mul_y;
  logic             mul_ovf;

  fx_mul_sat #(
    .WIDTH (WIDTH),
    .FRAC  (FRAC)
  ) u_mul (
    .a_i   (t_q),
    .b_i   (x_q),
    .y_o   (mul_y),
    .ovf_o (mul_ovf)
  );

  // Done depends on registers only, so the controller never sees an input-to-output path.
  assign done     = valid_q & (cnt_q == exp_q);
  assign init_cmd = bus.load_t & (bus.sel_t == CMD_INIT);
  // Iterates before any init or after done are dropped; this also keeps cnt from wrapping.
  assign iter_cmd = bus.load_t & (bus.sel_t == CMD_ITER) & valid_q & ~done;

  // Next-state decode for init / iterate / hold.
  always_comb begin
    t_d     = t_q;
    x_d     = x_q;
    exp_d   = exp_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (init_cmd) begin
      x_d     = bus.x_in;
      exp_d   = bus.exp_in;
      ovf_d   = 1'b0;
      valid_d = 1'b1;
      if (bus.exp_in == '0) begin
        t_d   = OneFx;
        cnt_d = '0;
      end else begin
        t_d   = bus.x_in;
        cnt_d = CNT_W'(1);
      end
    end else if (iter_cmd) begin
      t_d   = mul_y;
      ovf_d = ovf_q | mul_ovf;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers; synchronous reset wins over any command in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_q     <= '0;
      x_q     <= '0;
      exp_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      t_q     <= t_d;
      x_q     <= x_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.result        = t_q;
  assign bus.datapath_done = done;
  assign bus.overflow      = ovf_q;

endmodule

// File: tb/tb_iter_power_datapath.sv
// Scoreboard bench for iter_power_datapath: the driver applies one command per cycle and
// queues the hand-computed outputs expected after that edge; the monitor pops and compares.
module tb_iter_power_datapath;
  import iter_power_datapath_pkg::*;

  typedef struct packed {
    logic [15:0] res;
    logic        done;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   step_no  = 0;

  iter_power_datapath_if #(.WIDTH(16), .CNT_W(4)) bus ();

  iter_power_datapath #(
    .WIDTH (16),
    .FRAC  (8),
    .CNT_W (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus, then queue what the outputs must be after the edge.
  task automatic step(input logic r, input logic ld, input logic sel, input logic [15:0] x,
                      input logic [3:0] e, input logic [15:0] res, input logic dn,
                      input logic ov);
    exp_t item;
    rst        = r;
    bus.load_t = ld;
    bus.sel_t  = sel;
    bus.x_in   = x;
    bus.exp_in = e;
    @(posedge clk);
    #1;
    item.res  = res;
    item.done = dn;
    item.ovf  = ov;
    exp_q.push_back(item);
  endtask

  task automatic init(input logic [15:0] x, input logic [3:0] e, input logic [15:0] res,
                      input logic dn);
    step(1'b0, 1'b1, CMD_INIT, x, e, res, dn, 1'b0);
  endtask

  task automatic iter(input logic [15:0] res, input logic dn, input logic ov);
    step(1'b0, 1'b1, CMD_ITER, 16'hDEAD, 4'hF, res, dn, ov);
  endtask

  // Monitor: compare whenever an expectation is pending, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      exp_t a;
      e = exp_q.pop_front();
      a.res  = bus.result;
      a.done = bus.datapath_done;
      a.ovf  = bus.overflow;
      n_checks++;
      step_no++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL step%0d: got result=%h done=%b ovf=%b, want result=%h done=%b ovf=%b",
                 step_no, a.res, a.done, a.ovf, e.res, e.done, e.ovf);
      end
    end
  end

  initial begin
    bus.load_t = 1'b0;
    bus.sel_t  = 1'b0;
    bus.x_in   = '0;
    bus.exp_in = '0;

    // Reset, then idle.
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 16'h0000, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 16'h0, 4'h0, 16'h0000, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 16'h0, 4'h0, 16'h0000, 1'b0, 1'b0);

    // Iterate with no prior init is ignored.
    iter(16'h0000, 1'b0, 1'b0);

    // 2.0^3.
    init(16'h0200, 4'd3, 16'h0200, 1'b0);
    iter(16'h0400, 1'b0, 1'b0);
    iter(16'h0800, 1'b1, 1'b0);
    iter(16'h0800, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b1, 16'h0, 4'h0, 16'h0800, 1'b1, 1'b0);

    // 16.0^3 saturates on the first iterate and stays saturated.
    init(16'h1000, 4'd3, 16'h1000, 1'b0);
    iter(16'hFFFF, 1'b0, 1'b1);
    iter(16'hFFFF, 1'b1, 1'b1);
    iter(16'hFFFF, 1'b1, 1'b1);

    // N=0 yields 1.0 immediately; further iterates ignored. N=1 yields x immediately.
    init(16'h0380, 4'd0, ONE_FX, 1'b1);
    iter(ONE_FX, 1'b1, 1'b0);
    init(16'h0180, 4'd1, 16'h0180, 1'b1);

    // 1.5^2 = 2.25.
    init(16'h0180, 4'd2, 16'h0180, 1'b0);
    iter(16'h0240, 1'b1, 1'b0);

    // Restart mid-operation after overflow: overflow clears, 3.0^2 = 9.0.
    init(16'h1000, 4'd3, 16'h1000, 1'b0);
    iter(16'hFFFF, 1'b0, 1'b1);
    init(16'h0300, 4'd2, 16'h0300, 1'b0);
    iter(16'h0900, 1'b1, 1'b0);

    // Largest exponent: 1.0^15 takes 14 iterates, done only on the last.
    init(ONE_FX, 4'd15, ONE_FX, 1'b0);
    for (int i = 1; i <= 14; i++) iter(ONE_FX, (i == 14), 1'b0);
    iter(ONE_FX, 1'b1, 1'b0);

    // Reset together with an iterate command mid-operation; reset wins, state is gone.
    init(16'h0200, 4'd3, 16'h0200, 1'b0);
    iter(16'h0400, 1'b0, 1'b0);
    step(1'b1, 1'b1, CMD_ITER, 16'h0, 4'h0, 16'h0000, 1'b0, 1'b0);
    iter(16'h0000, 1'b0, 1'b0);

    bus.load_t = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
